// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared types for the MMCM DRP reprogramming sequencer: FSM states,
// error codes, DRP widths and the table entry layout.
package mmcm_drp_sequencer_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_RELEASE,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DRDY = 2'd1,
    ERR_LOCK = 2'd2
  } err_t;

  // 39-bit table entry: mask bit 1 keeps the live DRP bit, 0 takes data
  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] data;
    logic [DRP_DW-1:0] mask;
  } tbl_entry_t;

  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] cur,
                                                  input tbl_entry_t e);
    return (cur & e.mask) | (e.data & ~e.mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_sequencer_table.sv
// Host-loaded DRP entry table: one write port, one asynchronous read port.
// Contents are deliberately not reset.
module mmcm_drp_sequencer_table
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter  int pNUM_ENTRIES = 8,
  localparam int IW           = $clog2(pNUM_ENTRIES)
) (
  input  logic          clk_usb,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  tbl_entry_t    wdata_i,
  input  logic [IW-1:0] ridx_i,
  output tbl_entry_t    rdata_o
);

  tbl_entry_t mem_q [pNUM_ENTRIES];

  // write port
  always_ff @(posedge clk_usb) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// Atomic MMCM reprogramming: hold reset, read-modify-write each table entry
// over DRP, release reset, then wait for a synchronized lock.
module mmcm_drp_sequencer
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter  int pNUM_ENTRIES  = 8,
  parameter  int pRST_HOLD     = 16,
  parameter  int pDRDY_TIMEOUT = 64,
  parameter  int pLOCK_TIMEOUT = 65535,
  localparam int IW            = $clog2(pNUM_ENTRIES)
) (
  input  logic              clk_usb,
  input  logic              reset_n,
  input  logic              tbl_we,
  input  logic [IW-1:0]     tbl_idx,
  input  logic [DRP_AW-1:0] tbl_addr,
  input  logic [DRP_DW-1:0] tbl_data,
  input  logic [DRP_DW-1:0] tbl_mask,
  input  logic [IW:0]       cfg_count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              mmcm_rst_o,
  input  logic              mmcm_locked_i,
  output logic [DRP_AW-1:0] drp_addr,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_DW-1:0] drp_din,
  input  logic [DRP_DW-1:0] drp_dout,
  input  logic              drp_drdy
);

  localparam logic [31:0] HOLD_LAST = 32'(pRST_HOLD - 1);
  localparam logic [31:0] DRDY_LAST = 32'(pDRDY_TIMEOUT - 1);
  localparam logic [31:0] LOCK_LAST = 32'(pLOCK_TIMEOUT - 1);
  localparam logic [IW:0] NUM_MAX   = (IW+1)'(pNUM_ENTRIES);

  state_t            state_q, state_d;
  logic [31:0]       cnt_q;
  logic [IW:0]       idx_q, num_q, idx_nxt, num_clamped;
  logic [DRP_DW-1:0] rdat_q;
  err_t              err_q;
  logic [1:0]        sync_q;
  logic              lprev_q, rst_q, done_q;
  logic              locked_s, lock_ok, drdy_to, lock_to;
  tbl_entry_t        ent;

  mmcm_drp_sequencer_table #(.pNUM_ENTRIES(pNUM_ENTRIES)) u_table (
    .clk_usb (clk_usb),
    .we_i    (tbl_we && (state_q == S_IDLE)),
    .widx_i  (tbl_idx),
    .wdata_i ('{addr: tbl_addr, data: tbl_data, mask: tbl_mask}),
    .ridx_i  (idx_q[IW-1:0]),
    .rdata_o (ent)
  );

  assign locked_s    = sync_q[1];
  // both lock samples must fall inside LOCK_WAIT, hence cnt_q != 0
  assign lock_ok     = locked_s && lprev_q && (cnt_q != '0);
  assign idx_nxt     = idx_q + 1'b1;
  assign num_clamped = (cfg_count > NUM_MAX) ? NUM_MAX : cfg_count;
  assign drdy_to     = ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) &&
                       !drp_drdy && (cnt_q == DRDY_LAST);
  assign lock_to     = (state_q == S_LOCK_WAIT) && !lock_ok && (cnt_q == LOCK_LAST);

  // state register
  always_ff @(posedge clk_usb) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_RST_HOLD;
      S_RST_HOLD:  if (cnt_q == HOLD_LAST) state_d = (num_q == '0) ? S_RELEASE : S_RD;
      S_RD:        state_d = S_RD_WAIT;
      S_RD_WAIT:   if (drp_drdy) state_d = S_WR;
                   else if (drdy_to) state_d = S_DONE;
      S_WR:        state_d = S_WR_WAIT;
      S_WR_WAIT:   if (drp_drdy) state_d = (idx_nxt == num_q) ? S_RELEASE : S_RD;
                   else if (drdy_to) state_d = S_DONE;
      S_RELEASE:   state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: if (lock_ok || lock_to) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // counters, datapath, error flags, lock synchronizer and registered outputs
  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      rdat_q  <= '0;
      err_q   <= ERR_NONE;
      sync_q  <= '0;
      lprev_q <= 1'b0;
      rst_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], mmcm_locked_i};
      lprev_q <= locked_s;
      cnt_q   <= ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 32'd1;
      // registered so the MMCM reset never glitches on state decode
      rst_q   <= state_d inside {S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT};
      // done lands in the first IDLE cycle, together with busy falling
      done_q  <= (state_q == S_DONE);
      if ((state_q == S_IDLE) && start) begin
        idx_q <= '0;
        num_q <= num_clamped;
        err_q <= ERR_NONE;
      end
      if ((state_q == S_RD_WAIT) && drp_drdy) rdat_q <= drp_dout;
      if ((state_q == S_WR_WAIT) && drp_drdy) idx_q  <= idx_nxt;
      if (drdy_to) err_q <= ERR_DRDY;
      if (lock_to) err_q <= ERR_LOCK;
    end
  end

  // output decode: DRP bus is zero except during the single den cycle
  always_comb begin
    busy     = (state_q != S_IDLE);
    drp_den  = 1'b0;
    drp_dwe  = 1'b0;
    drp_addr = '0;
    drp_din  = '0;
    unique case (state_q)
      S_RD: begin
        drp_den  = 1'b1;
        drp_addr = ent.addr;
      end
      S_WR: begin
        drp_den  = 1'b1;
        drp_dwe  = 1'b1;
        drp_addr = ent.addr;
        drp_din  = drp_merge(rdat_q, ent);
      end
      default: ;
    endcase
  end

  assign done       = done_q;
  assign mmcm_rst_o = rst_q;
  assign error      = (err_q != ERR_NONE);
  assign err_code   = err_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP slave and MMCM lock models, a DRP
// transaction scoreboard, a vector table and hand-written corner sequences.
module tb_mmcm_drp_sequencer;

  logic        clk_usb = 1'b0;
  logic        reset_n;
  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_data, tbl_mask;
  logic [3:0]  cfg_count;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic        mmcm_rst_o, mmcm_locked_i;
  logic [6:0]  drp_addr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_din, drp_dout;
  logic        drp_drdy;

  int checks = 0;
  int errors = 0;

  mmcm_drp_sequencer #(.pLOCK_TIMEOUT(100)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_mask(tbl_mask),
    .cfg_count(cfg_count), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .mmcm_rst_o(mmcm_rst_o),
    .mmcm_locked_i(mmcm_locked_i), .drp_addr(drp_addr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_din(drp_din), .drp_dout(drp_dout), .drp_drdy(drp_drdy)
  );

  always #5 clk_usb = ~clk_usb;

  // ---------------- DRP slave model ----------------
  logic [15:0] drp_mem [128];
  logic        drdy_en;
  int          lat;
  logic        pend, p_we;
  logic [6:0]  p_addr;
  int          lat_cnt;

  always @(posedge clk_usb) begin
    drp_drdy <= 1'b0;
    if (!reset_n) begin
      pend     <= 1'b0;
      drp_dout <= '0;
    end else if (drp_den) begin
      pend    <= 1'b1;
      p_we    <= drp_dwe;
      p_addr  <= drp_addr;
      lat_cnt <= lat;
    end else if (pend) begin
      if (lat_cnt == 0) begin
        pend <= 1'b0;
        if (drdy_en) begin
          drp_drdy <= 1'b1;
          drp_dout <= p_we ? 16'h0000 : drp_mem[p_addr];
        end
      end else lat_cnt <= lat_cnt - 1;
    end
  end

  // ---------------- MMCM lock model ----------------
  logic lock_en;
  int   lk_cnt;
  always @(posedge clk_usb) begin
    if (!reset_n || mmcm_rst_o || !lock_en) begin
      lk_cnt        <= 0;
      mmcm_locked_i <= 1'b0;
    end else if (lk_cnt < 5) lk_cnt <= lk_cnt + 1;
    else mmcm_locked_i <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic we; logic [6:0] addr; logic [15:0] din; } sb_t;
  sb_t  exp_q [$];
  logic den_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(negedge clk_usb) begin
    if (reset_n) begin
      if (drp_den) begin
        chk("den_back_to_back", {31'd0, den_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_den: we=%0b addr=%0h din=%0h", drp_dwe, drp_addr, drp_din);
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("drp_we",   {31'd0, drp_dwe}, {31'd0, e.we});
          chk("drp_addr", {25'd0, drp_addr}, {25'd0, e.addr});
          if (e.we) chk("drp_din", {16'd0, drp_din}, {16'd0, e.din});
        end
      end else begin
        chk("drp_idle_zero", {8'd0, drp_dwe, drp_addr, drp_din}, 32'd0);
      end
    end
    den_prev = drp_den && reset_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_usb); #1;
  endtask

  task automatic load(input int idx, input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
    tbl_we = 1'b1; tbl_idx = idx[2:0]; tbl_addr = a; tbl_data = d; tbl_mask = m;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic push_rmw(input logic [6:0] a, input logic [15:0] din);
    exp_q.push_back('{we: 1'b0, addr: a, din: 16'h0});
    exp_q.push_back('{we: 1'b1, addr: a, din: din});
  endtask

  // pulse start, then run until done; reports cycle indices of first den,
  // reset fall, done, the count of reset-high cycles and error after start
  task automatic run_seq(input int max, output int k_done, output int k_den,
                         output int k_fall, output int rst_cyc, output logic err0);
    logic seen_rst;
    k_done = -1; k_den = -1; k_fall = -1; rst_cyc = 0; seen_rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0; tbl_we = 1'b0;
    err0 = error;
    for (int k = 0; k < max; k++) begin
      if (done) begin k_done = k; break; end
      if (mmcm_rst_o) begin rst_cyc++; seen_rst = 1'b1; end
      else if (seen_rst && k_fall < 0) k_fall = k;
      if (drp_den && k_den < 0) k_den = k;
      tick();
    end
    checks++;
    if (k_done < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
  endtask

  task automatic end_checks(input string nm, input logic exp_err, input logic [1:0] exp_code);
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({nm, "_error"}, {31'd0, error}, {31'd0, exp_err});
    chk({nm, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
    chk({nm, "_rst_at_done"}, {31'd0, mmcm_rst_o}, 32'd0);
    chk({nm, "_sb_empty"}, exp_q.size(), 32'd0);
    tick();
    chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data, mask, cur, exp_din;
  } vec_t;

  initial begin
    vec_t vec [5];
    int   k_done, k_den, k_fall, rst_cyc;
    logic err0;

    vec[0] = '{7'h08, 16'h1041, 16'hE000, 16'hFFFF, 16'hF041};
    vec[1] = '{7'h09, 16'hABCD, 16'h0000, 16'h1234, 16'hABCD};
    vec[2] = '{7'h0A, 16'hABCD, 16'hFFFF, 16'h1234, 16'h1234};
    vec[3] = '{7'h4F, 16'h00FF, 16'hF0F0, 16'h5A5A, 16'h505F};
    vec[4] = '{7'h7F, 16'hFFFF, 16'h00FF, 16'h0000, 16'hFF00};

    for (int i = 0; i < 128; i++) drp_mem[i] = 16'(i * 16'h0111);
    reset_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    tbl_mask = '0; cfg_count = '0; start = 1'b0; drdy_en = 1'b1; lat = 2; lock_en = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_mmcm_rst", {31'd0, mmcm_rst_o}, 32'd0);
    chk("rst_den", {31'd0, drp_den}, 32'd0);
    reset_n = 1'b1;
    tick();

    // single-entry read-modify-write vectors
    for (int v = 0; v < 5; v++) begin
      drp_mem[vec[v].addr] = vec[v].cur;
      load(0, vec[v].addr, vec[v].data, vec[v].mask);
      cfg_count = 4'd1;
      push_rmw(vec[v].addr, vec[v].exp_din);
      run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
      chk("vec_rst_cycles", rst_cyc, 16 + 2 * (lat + 3));
      end_checks("vec", 1'b0, 2'd0);
    end

    // cfg_count = 0: reset pulse only, no DRP traffic
    cfg_count = 4'd0;
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    chk("cnt0_rst_cycles", rst_cyc, 16);
    chk("cnt0_no_den", k_den, -1);
    end_checks("cnt0", 1'b0, 2'd0);

    // DRDY never arrives
    drdy_en = 1'b0;
    load(0, 7'h08, 16'h1041, 16'hE000);
    cfg_count = 4'd1;
    exp_q.push_back('{we: 1'b0, addr: 7'h08, din: 16'h0});
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    chk_rng("drdy_to_latency", k_done - k_den, 64, 66);
    end_checks("drdy_to", 1'b1, 2'd1);
    drdy_en = 1'b1;

    // lock never comes; start must clear the sticky DRDY error first
    lock_en = 1'b0;
    cfg_count = 4'd0;
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    chk("lock_to_err_cleared", {31'd0, err0}, 32'd0);
    chk_rng("lock_to_latency", k_done - k_fall, 100, 102);
    end_checks("lock_to", 1'b1, 2'd2);
    lock_en = 1'b1;
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    chk("lock_retry_err_cleared", {31'd0, err0}, 32'd0);
    end_checks("lock_retry", 1'b0, 2'd0);

    // table write coincident with start: the new entry is used
    load(0, 7'h10, 16'h0000, 16'h0000);
    drp_mem[7'h11] = 16'hC3C3;
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_addr = 7'h11; tbl_data = 16'h0F0F; tbl_mask = 16'hFF00;
    cfg_count = 4'd1;
    push_rmw(7'h11, 16'hC30F);
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    end_checks("we_start", 1'b0, 2'd0);

    // 8 entries, clamped count, extra starts and table writes while busy
    for (int i = 0; i < 8; i++) begin
      logic [6:0]  a;
      logic [15:0] d, m;
      a = 7'(7'h20 + i);
      d = 16'(16'h1357 * (i + 1));
      m = 16'(16'h0F0F << i);
      drp_mem[a] = 16'(16'hA5A5 ^ (i * 16'h1111));
      load(i, a, d, m);
      push_rmw(a, (drp_mem[a] & m) | (d & ~m));
    end
    cfg_count = 4'd9;
    fork
      run_seq(800, k_done, k_den, k_fall, rst_cyc, err0);
      begin
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 8; j++) load(j, 7'(7'h60 + j), 16'hDEAD, 16'h0000);
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
      end
    join
    chk("full_rst_cycles", rst_cyc, 16 + 8 * 2 * (lat + 3));
    end_checks("full", 1'b0, 2'd0);
    repeat (5) tick();
    chk("full_no_restart", {31'd0, busy}, 32'd0);

    // reset in the middle of WR_WAIT, then a clean run
    lat = 20;
    load(0, 7'h30, 16'h00AA, 16'hFF00);
    drp_mem[7'h30] = 16'h1234;
    cfg_count = 4'd1;
    push_rmw(7'h30, 16'h12AA);
    start = 1'b1; tick(); start = 1'b0;
    begin
      int w;
      w = 0;
      while (!(drp_den && drp_dwe) && w < 200) begin tick(); w++; end
      chk_rng("midrst_reach_wr", w, 0, 199);
    end
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    chk("midrst_mmcm_rst", {31'd0, mmcm_rst_o}, 32'd0);
    chk("midrst_drp", {8'd0, drp_den, drp_dwe, drp_addr, drp_din}, 32'd0);
    reset_n = 1'b1;
    lat = 2;
    tick();
    load(0, 7'h31, 16'hBEEF, 16'h0000);
    push_rmw(7'h31, 16'hBEEF);
    run_seq(400, k_done, k_den, k_fall, rst_cyc, err0);
    end_checks("post_rst", 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
